bram_32x1024_sdp: RTL and testbench

//   Simple dual-port block RAM: 1024 words x 32 bits, one write port (A), one read port (B).

---
 rtl/bram_32x1024_sdp.sv | 66 ++++++
 tb/tb_bram_32x1024_sdp.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bram_32x1024_sdp.sv
// bram_32x1024_sdp: simple dual-port block RAM, one write port (A) and one read port (B).
// Both ports share one clock. Collisions on the same address are resolved write-first.
// Optional feature macro: BRAM_OUT_REG_EN adds an output register, giving 2-cycle read latency.
// Reset clears only the read pipeline. The array and the write port ignore reset.

module bram_32x1024_sdp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              w_collide;

  // A write and a read to the same address on one edge return the new data.
  assign w_collide = wea && (addra == addrb);

  // Write port. It has no reset, so data written while reset is low is kept.
  always_ff @(posedge clk) begin
    if (wea) begin
      r_mem[addra] <= dina;
    end
  end

  // Synchronous read stage. It is cleared by reset and holds its value while enb is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout <= '0;
    end else if (enb) begin
      r_dout <= w_collide ? dina : r_mem[addrb];
    end
  end

`ifdef BRAM_OUT_REG_EN
  logic              r_enb_d;
  logic [DATA_W-1:0] r_dout_reg;

  // The output register loads one cycle after the read that filled r_dout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enb_d    <= 1'b0;
      r_dout_reg <= '0;
    end else begin
      r_enb_d <= enb;
      if (r_enb_d) begin
        r_dout_reg <= r_dout;
      end
    end
  end

  assign doutb = r_dout_reg;
`else
  assign doutb = r_dout;
`endif

endmodule

// File: tb/tb_bram_32x1024_sdp.sv
// Directed testbench for bram_32x1024_sdp. It works with either read latency.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at the same point.

module tb_bram_32x1024_sdp;

`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        wea;
  logic [9:0]  addra;
  logic [31:0] dina;
  logic        enb;
  logic [9:0]  addrb;
  logic [31:0] doutb;

  int n_vec;
  int n_err;

  bram_32x1024_sdp dut (
    .clk   (clk),
    .reset (reset),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    wea = 1'b1; addra = a; dina = d;
    tick();
    wea = 1'b0;
  endtask

  // Issue one read, then wait until its data has reached doutb.
  task automatic rd(input logic [9:0] a);
    enb = 1'b1; addrb = a;
    tick();
    enb = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0; wea = 1'b0; enb = 1'b0;
    addra = '0; addrb = '0; dina = '0;
    #2;
    check_eq("reset_dout", doutb, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Basic write then read.
    wr(10'd5, 32'hDEADBEEF);
    rd(10'd5);
    check_eq("rd_5", doutb, 32'hDEADBEEF);

    // With wea low, the memory must not change.
    wea = 1'b0; addra = 10'd5; dina = 32'h0BADF00D;
    tick();
    rd(10'd5);
    check_eq("wea0_keep", doutb, 32'hDEADBEEF);

    // Write-first collision: address 10 first holds an older value.
    wr(10'd10, 32'hAAAA0000);
    wea = 1'b1; addra = 10'd10; dina = 32'h12345678; enb = 1'b1; addrb = 10'd10;
    tick();
    wea = 1'b0; enb = 1'b0;
    repeat (LAT - 1) tick();
    check_eq("collide", doutb, 32'h12345678);
    rd(10'd10);
    check_eq("collide_stored", doutb, 32'h12345678);

    // Hold: doutb keeps its value while enb is low and the addresses change.
    wr(10'd20, 32'hA5A5A5A5);
    wr(10'd21, 32'h11111111);
    rd(10'd20);
    check_eq("hold_load", doutb, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      addrb = 10'(21 + i);
      tick();
      check_eq("hold", doutb, 32'hA5A5A5A5);
    end

    // Asynchronous reset between edges, with a write issued while reset is low.
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_rst", doutb, 32'h0);
    @(posedge clk); #1;
    wr(10'd7, 32'h55);
    check_eq("rst_hold_zero", doutb, 32'h0);
    reset = 1'b1;
    rd(10'd7);
    check_eq("rd_after_rst", doutb, 32'h55);

    // Fill every word with the inverse of its address, then read all words back.
    for (int i = 0; i < 1024; i++) wr(10'(i), ~32'(i));
    for (int i = 0; i < 1024; i++) begin
      rd(10'(i));
      check_eq("fill", doutb, ~32'(i));
    end

    // Line delay: write at raddr+639 and read every cycle. Run across several address wraps.
    for (int k = 0; k < 2200; k++) begin
      wea = 1'b1; addra = 10'((k + 639) % 1024); dina = 32'(k);
      enb = 1'b1; addrb = 10'(k % 1024);
      tick();
      if (k >= 639 + LAT - 1) check_eq("line_delay", doutb, 32'(k - 639 - (LAT - 1)));
    end
    wea = 1'b0; enb = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
